// File: rtl/conv_pkg.sv
// Shared parameters and FSM encoding for the convolution pipeline stages.
package conv_pkg;

  localparam int unsigned DATA_W_DEF   = 4;
  localparam int unsigned ACC_W_DEF    = 12;
  localparam int unsigned KERNEL_N_DEF = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } conv_state_e;

  // Counter width able to hold 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tap_counter.sv
// Counts accepted taps within a window; tc_c flags that the next beat completes it.
module tap_counter
  import conv_pkg::*;
#(
  parameter int unsigned KERNEL_N = KERNEL_N_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_c
);

  localparam int unsigned CNT_W = cnt_width(KERNEL_N);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == CNT_W'(KERNEL_N - 1));

endmodule

// File: rtl/conv_accumulator.sv
// Saturating window accumulator: sums KERNEL_N partial sums and holds the result until taken.
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned KERNEL_N = KERNEL_N_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat
);

  localparam int unsigned SUM_W = ACC_W + 1;

  conv_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic              out_sat_q, out_sat_d;
  logic              cnt_clr, cnt_inc, last_tap;
  logic              accept;
  logic [SUM_W-1:0]  sum;

  tap_counter #(.KERNEL_N(KERNEL_N)) u_tap_counter (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_c  (last_tap)
  );

  assign accept = in_valid && in_ready_q && !clear;
  assign sum    = {1'b0, acc_q} + SUM_W'(in_data);

  // Next state; outputs are precomputed from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      sat_d   = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            acc_d   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            sat_d   = sat_q | sum[ACC_W];
            cnt_inc = 1'b1;
            state_d = last_tap ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            sat_d   = 1'b0;
            cnt_clr = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          sat_d   = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end

    out_valid_d = (state_d == ST_HOLD);
    in_ready_d  = !out_valid_d;
    out_data_d  = out_valid_d ? acc_d : '0;
    out_sat_d   = out_valid_d & sat_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed vector bench for conv_accumulator across three parameterisations.
module tb_conv_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_clear, a_iv, a_ordy, a_ir, a_ov, a_sat;
  logic [3:0]  a_d;
  logic [11:0] a_out;
  logic        b_clear, b_iv, b_ordy, b_ir, b_ov, b_sat;
  logic [3:0]  b_d;
  logic [5:0]  b_out;
  logic        c_clear, c_iv, c_ordy, c_ir, c_ov, c_sat;
  logic [3:0]  c_d;
  logic [11:0] c_out;

  conv_accumulator #(.DATA_W(4), .ACC_W(12), .KERNEL_N(9)) u_a (
    .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_iv), .in_data(a_d),
    .in_ready(a_ir), .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_out), .out_sat(a_sat)
  );

  conv_accumulator #(.DATA_W(4), .ACC_W(6), .KERNEL_N(9)) u_b (
    .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_iv), .in_data(b_d),
    .in_ready(b_ir), .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_out), .out_sat(b_sat)
  );

  conv_accumulator #(.DATA_W(4), .ACC_W(12), .KERNEL_N(1)) u_c (
    .clk(clk), .rst(rst), .clear(c_clear), .in_valid(c_iv), .in_data(c_d),
    .in_ready(c_ir), .out_valid(c_ov), .out_ready(c_ordy), .out_data(c_out), .out_sat(c_sat)
  );

  typedef struct {
    int sel;
    bit clr;
    bit iv;
    int d;
    bit ordy;
    bit eir;
    bit eov;
    int edata;
    bit esat;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic int pack(input bit ir, input bit ov, input bit sat, input int data);
    return (int'(ir) << 14) | (int'(ov) << 13) | (int'(sat) << 12) | data;
  endfunction

  function automatic int observe(input int sel);
    case (sel)
      0:       return pack(a_ir, a_ov, a_sat, int'(a_out));
      1:       return pack(b_ir, b_ov, b_sat, int'(b_out));
      default: return pack(c_ir, c_ov, c_sat, int'(c_out));
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input bit clr, input bit iv, input int d, input bit ordy);
    case (sel)
      0:       begin a_clear = clr; a_iv = iv; a_d = 4'(d); a_ordy = ordy; end
      1:       begin b_clear = clr; b_iv = iv; b_d = 4'(d); b_ordy = ordy; end
      default: begin c_clear = clr; c_iv = iv; c_d = 4'(d); c_ordy = ordy; end
    endcase
  endtask

  function automatic void add(input int sel, input bit clr, input bit iv, input int d,
                              input bit ordy, input bit eir, input bit eov,
                              input int edata, input bit esat);
    vec_t v;
    v.sel = sel; v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.edata = edata; v.esat = esat;
    vecs.push_back(v);
  endfunction

  function automatic void add_beats(input int sel, input int n, input int d);
    for (int k = 0; k < n; k++) add(sel, 1'b0, 1'b1, d, 1'b1, 1'b1, 1'b0, 0, 1'b0);
  endfunction

  function automatic void add_idle(input int sel);
    add(sel, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
  endfunction

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);

    // Default window of nine 9s, then result held under backpressure
    add_beats(0, 9, 9);
    add(0, 0, 0, 0, 1, 0, 1, 81, 0);
    add_idle(0);
    add_beats(0, 9, 9);
    for (int k = 0; k < 5; k++) add(0, 0, 1, 9, 0, 0, 1, 81, 0);
    add(0, 0, 1, 9, 1, 0, 1, 81, 0);
    add_idle(0);
    add_beats(0, 9, 1);
    add(0, 0, 0, 0, 1, 0, 1, 9, 0);
    add_idle(0);
    // clear on beat 5 drops the beat and the window
    add_beats(0, 4, 1);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0);
    add_beats(0, 9, 1);
    add(0, 0, 0, 0, 1, 0, 1, 9, 0);
    add_idle(0);
    // clear while a result is pending
    add_beats(0, 9, 2);
    add(0, 1, 0, 0, 0, 0, 1, 18, 0);
    add_idle(0);
    add_idle(0);
    // ACC_W=6 saturation, then sticky bit cleared for the next window
    add_beats(1, 9, 15);
    add(1, 0, 0, 0, 1, 0, 1, 63, 1);
    add_idle(1);
    add_beats(1, 9, 1);
    add(1, 0, 0, 0, 1, 0, 1, 9, 0);
    add_idle(1);
    // KERNEL_N=1: every beat is a full window
    add(2, 0, 1, 7, 1, 1, 0, 0, 0);
    add(2, 0, 1, 5, 1, 0, 1, 7, 0);
    add(2, 0, 1, 5, 1, 1, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 1, 5, 0);
    add_idle(2);

    repeat (2) @(negedge clk);
    check("reset_a", observe(0), pack(1, 0, 0, 0));
    check("reset_b", observe(1), pack(1, 0, 0, 0));
    check("reset_c", observe(2), pack(1, 0, 0, 0));
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      check($sformatf("vec%0d", i), observe(vecs[i].sel),
            pack(vecs[i].eir, vecs[i].eov, vecs[i].esat, vecs[i].edata));
    end

    // Async reset mid-window discards the four beats of 3
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 3, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    #2 rst = 1'b0;
    #1 check("rst_mid_window", observe(0), pack(1, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(0, 0, 1, 2, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 5 && !a_ov; k++) @(negedge clk);
    check("rst_recover_valid", int'(a_ov), 1);
    check("rst_recover_data", int'(a_out), 18);

    // Async reset while holding a result clears outputs before any clock edge
    #2 rst = 1'b0;
    #1 check("rst_in_hold", observe(0), pack(1, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", observe(0), pack(1, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
